input_request_ctrl: RTL and testbench
=====================================

Name: input_request_ctrl

Overview:
- Front end for the switch/button input path of the processor.
- Synchronises the 4 raw data switches and the raw "enter" button, debounces the button, and serialises one capture per CPU input request.
- While an IN-type instruction is pending, holds the CPU with `stall`. On a debounced press it emits a one-cycle `in_pulse` with stable `data_out`; these drive the `in` and `data` pins of the downstream 32-bit input register.

Parameters:
- DATA_W, 4, width of the switch bus and of `data_out`.
- SYNC_STAGES, 2, flip-flop stages on each raw input (minimum 2).
- DEBOUNCE_CYCLES, 50000, number of consecutive stable cycles required before the debounced button level changes (1 ms at 50 MHz).

Ports:
- clock, input, 1, system clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-high reset.
- chaves, input, DATA_W, raw asynchronous switch levels.
- botao, input, 1, raw asynchronous button level, 1 = pressed.
- req_in, input, 1, CPU is executing an input instruction; held high until `stall` drops.
- data_out, output, DATA_W, captured switch value; to the downstream `data`.
- in_pulse, output, 1, one-cycle capture strobe; to the downstream `in`.
- stall, output, 1, CPU hold request.

Behaviour:
- Reset (synchronous, checked at rising edge):
  - All sync flops, debounced level `btn_db`, counter, FSM (IDLE), `data_out` and `in_pulse` clear to 0.
  - `stall` is forced 0 while `reset` is high.
  - Reset mid-capture aborts the capture; no `in_pulse` is issued.
- Sync: `chaves` and `botao` each pass through SYNC_STAGES flops, giving `sw_s` and `btn_s`.
- Debounce:
  - If `btn_s` equals `btn_db`, the counter clears.
  - Otherwise the counter increments. On the cycle the counter equals DEBOUNCE_CYCLES-1, `btn_db` takes `btn_s` and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES); the counter must never wrap.
- Press event: `btn_db` rises 0->1 (registered previous value vs current). Release events are ignored.
- FSM, registered state:
  - IDLE: if `req_in`, go to WAIT_PRESS. Press events in IDLE are discarded, not queued.
  - WAIT_PRESS:
    - On a press event: `data_out` <= `sw_s`, go to CAPTURE.
    - If `req_in` drops with no press (CPU flush): go to IDLE, no capture.
    - Press event and `req_in` low in the same cycle: return to IDLE with no capture.
  - CAPTURE: `in_pulse` = 1 for exactly this cycle, `data_out` stable; go to DONE.
  - DONE: `in_pulse` = 0, `stall` = 0; go to IDLE unconditionally.
- Registered outputs:
  - `in_pulse` and `data_out` are registered.
  - `data_out` holds its last captured value until the next capture.
- Downstream timing: the downstream register samples on the rising edge that ends CAPTURE, so its output is valid in DONE, when the CPU is released.
- Stall (combinational): `stall` = `req_in` & ~`reset` & (state is IDLE, WAIT_PRESS or CAPTURE). It rises the same cycle `req_in` rises.
- Back-to-back requests: a second `req_in` seen in IDLE right after DONE requires a fresh press. A button still held from the previous capture does not count; it must release (debounced) and press again.
- Switch changes after capture do not alter `data_out`.

Decomposition:
- Shared package: FSM state enum {IDLE, WAIT_PRESS, CAPTURE, DONE}, the DATA_W default, and the default DEBOUNCE_CYCLES constant.
- One sub-module, `button_debouncer` (sync chain + counter + `btn_db` + rise detect), outputs `press_evt`.
- The switch synchroniser and FSM stay in the top.

Test Plan (sim with SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset held 3 cycles with `req_in`=1 -> `stall`=0, `data_out`=0, `in_pulse`=0. After release, `stall`=1 in the same cycle.
- `chaves`=4'b1011, `req_in`=1, `botao` high 10 cycles -> single `in_pulse` = 2+4+1 cycles after the press plus the FSM cycle. `data_out`=4'hB. `stall` low exactly one cycle (DONE). Downstream `saida`=32'h0000000B.
- Bounce: `botao` toggles 1,0,1,0 each cycle, then steady 1 -> exactly one `in_pulse`, timed from the start of the steady level.
- Press while `req_in`=0, then `req_in`=1 with the button still held -> no `in_pulse` until release plus a new press. Second press with `chaves`=4'h3 -> `data_out`=4'h3.
- Two consecutive requests (`req_in` re-asserted in IDLE after DONE), presses with `chaves`=4'h5 then 4'hF -> two pulses, `data_out` 5 then F, `stall` low only in each DONE.
- `req_in` dropped in WAIT_PRESS -> return to IDLE, no pulse, `data_out` unchanged. Reset asserted in CAPTURE -> no pulse on the following cycle.

Source files
------------

// File: rtl/input_request_ctrl_pkg.sv
// rtl/input_request_ctrl_pkg.sv - shared types and defaults for the switch/button input front end
package input_request_ctrl_pkg;

    localparam int DATA_W_DEF          = 4;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/input_request_ctrl_button_debouncer.sv
// rtl/input_request_ctrl_button_debouncer.sv - button synchroniser, debounce counter and press detect
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic press_evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic                   btn_db;
    logic                   btn_db_q;
    logic [CNT_W-1:0]       cnt;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], botao};
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // debounced one; it clears on reaching the last count, so it never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                btn_db <= btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press_evt = btn_db & ~btn_db_q;

endmodule

// File: rtl/input_request_ctrl.sv
// rtl/input_request_ctrl.sv - serialises one switch capture per CPU input request, stalling the CPU meanwhile
module input_request_ctrl
    import input_request_ctrl_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] chaves,
    input  logic              botao,
    input  logic              req_in,
    output logic [DATA_W-1:0] data_out,
    output logic              in_pulse,
    output logic              stall
);

    logic [DATA_W-1:0] sw_pipe [SYNC_STAGES];
    logic [DATA_W-1:0] sw_s;
    logic              press_evt;
    logic              capture;
    state_t            state;
    state_t            state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_pipe[i] <= '0;
            end
        end else begin
            sw_pipe[0] <= chaves;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_pipe[i] <= sw_pipe[i-1];
            end
        end
    end

    assign sw_s = sw_pipe[SYNC_STAGES-1];

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock    (clock),
        .reset    (reset),
        .botao    (botao),
        .press_evt(press_evt)
    );

    // A flush (req_in low) wins over a simultaneous press.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req_in) state_next = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!req_in) begin
                    state_next = IDLE;
                end else if (press_evt) begin
                    state_next = CAPTURE;
                    capture    = 1'b1;
                end
            end
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            in_pulse <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_next;
            in_pulse <= (state_next == CAPTURE);
            if (capture) data_out <= sw_s;
        end
    end

    assign stall = req_in & ~reset & (state != DONE);

endmodule

// File: tb/tb_input_request_ctrl.sv
// tb/tb_input_request_ctrl.sv - directed scoreboard bench for input_request_ctrl
module tb_input_request_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  chaves;
    logic        botao;
    logic        req_in;
    logic [3:0]  data_out;
    logic        in_pulse;
    logic        stall;
    logic [31:0] saida;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    logic [3:0] exp_q[$];

    input_request_ctrl #(
        .DATA_W         (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .chaves  (chaves),
        .botao   (botao),
        .req_in  (req_in),
        .data_out(data_out),
        .in_pulse(in_pulse),
        .stall   (stall)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) saida <= 32'h0;
        else if (in_pulse) saida <= {28'h0, data_out};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (in_pulse === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                check("pulse_data", {28'h0, data_out}, {28'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts edges until in_pulse; also flags any stall drop before the pulse.
    task automatic wait_pulse(input string tag, input int exp_lat);
        int k;
        int stall_drop;
        stall_drop = 0;
        for (k = 1; k <= 30; k++) begin
            tick();
            if (in_pulse === 1'b1) break;
            if (stall !== 1'b1) stall_drop++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_stall_held"}, stall_drop, 0);
    endtask

    initial begin
        int prev;
        reset  = 1'b1;
        req_in = 1'b1;
        botao  = 1'b0;
        chaves = 4'hB;
        repeat (3) tick();
        check("reset_stall", stall, 1'b0);
        check("reset_data", data_out, 4'h0);
        check("reset_pulse", in_pulse, 1'b0);
        reset = 1'b0;
        #1;
        check("stall_after_reset", stall, 1'b1);

        // Single clean press
        botao = 1'b1;
        exp_q.push_back(4'hB);
        wait_pulse("press_b", 7);
        check("capture_stall", stall, 1'b1);
        tick();
        check("done_stall", stall, 1'b0);
        check("done_pulse", in_pulse, 1'b0);
        check("saida_b", saida, 32'h0000000B);
        req_in = 1'b0;
        repeat (3) tick();
        botao = 1'b0;
        repeat (10) tick();

        // Bouncing press
        req_in = 1'b1;
        chaves = 4'h7;
        botao = 1'b1; tick();
        botao = 1'b0; tick();
        botao = 1'b1; tick();
        botao = 1'b0; tick();
        botao = 1'b1;
        exp_q.push_back(4'h7);
        wait_pulse("bounce", 7);
        tick();
        req_in = 1'b0;
        botao  = 1'b0;
        repeat (10) tick();

        // Press before request; held button must not count
        chaves = 4'h9;
        botao  = 1'b1;
        repeat (10) tick();
        prev   = pulse_cnt;
        req_in = 1'b1;
        #1;
        check("held_stall", stall, 1'b1);
        repeat (12) tick();
        check("held_no_pulse", pulse_cnt, prev);
        botao = 1'b0;
        repeat (10) tick();
        check("release_no_pulse", pulse_cnt, prev);
        chaves = 4'h3;
        botao  = 1'b1;
        exp_q.push_back(4'h3);
        wait_pulse("press_3", 7);
        check("data_3", data_out, 4'h3);
        tick();
        req_in = 1'b0;
        botao  = 1'b0;
        repeat (10) tick();

        // Back-to-back requests
        req_in = 1'b1;
        chaves = 4'h5;
        botao  = 1'b1;
        exp_q.push_back(4'h5);
        wait_pulse("b2b_first", 7);
        tick();
        check("b2b_done1_stall", stall, 1'b0);
        check("saida_5", saida, 32'h00000005);
        tick();
        check("b2b_idle_stall", stall, 1'b1);
        prev = pulse_cnt;
        repeat (5) tick();
        check("b2b_held_no_pulse", pulse_cnt, prev);
        botao = 1'b0;
        repeat (10) tick();
        chaves = 4'hF;
        botao  = 1'b1;
        exp_q.push_back(4'hF);
        wait_pulse("b2b_second", 7);
        check("data_f", data_out, 4'hF);
        tick();
        check("b2b_done2_stall", stall, 1'b0);
        check("saida_f", saida, 32'h0000000F);
        chaves = 4'h2;
        req_in = 1'b0;
        botao  = 1'b0;
        repeat (10) tick();
        check("data_hold_after_switch_change", data_out, 4'hF);

        // Flush in WAIT_PRESS
        prev   = pulse_cnt;
        req_in = 1'b1;
        repeat (4) tick();
        chaves = 4'hA;
        req_in = 1'b0;
        tick();
        check("flush_stall", stall, 1'b0);
        botao = 1'b1;
        repeat (10) tick();
        check("flush_no_pulse", pulse_cnt, prev);
        check("flush_data", data_out, 4'hF);
        botao = 1'b0;
        repeat (10) tick();

        // Reset asserted during CAPTURE
        req_in = 1'b1;
        chaves = 4'hC;
        botao  = 1'b1;
        exp_q.push_back(4'hC);
        wait_pulse("pre_reset", 7);
        reset  = 1'b1;
        req_in = 1'b0;
        #1;
        check("reset_capture_stall", stall, 1'b0);
        tick();
        check("reset_abort_pulse", in_pulse, 1'b0);
        check("reset_abort_data", data_out, 4'h0);
        reset = 1'b0;
        botao = 1'b0;
        repeat (12) tick();

        check("queue_empty", exp_q.size(), 0);
        check("pulse_count", pulse_cnt, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
